// File: rtl/fft8_pkg.sv
// Shared types and helpers for the 8-point FFT output reorder path.
package fft8_pkg;
  localparam int DW    = 16;
  localparam int LOG2N = 3;
  localparam int N     = 1 << LOG2N;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int k = 0; k < LOG2N; k++) r[k] = a[LOG2N-1-k];
    return r;
  endfunction
endpackage

// File: rtl/fft8_reorder_bank.sv
// N-entry complex register file: one synchronous write port, one combinational read port.
module fft8_reorder_bank
  import fft8_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic [LOG2N-1:0] wr_addr,
  input  cplx_t            wr_data,
  input  logic [LOG2N-1:0] rd_addr,
  output cplx_t            rd_data
);
  cplx_t mem_q [N];
  cplx_t mem_d [N];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  // Sample storage carries no reset; validity is tracked by the owner's bank_full flags.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/fft8_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT results in, natural bin order out, 1 sample/cycle.
module fft8_bitrev_reorder
  import fft8_pkg::*;
#(
  parameter int DW    = fft8_pkg::DW,
  parameter int LOG2N = fft8_pkg::LOG2N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_r,
  input  logic signed [DW-1:0] in_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i,
  output logic [LOG2N-1:0]     out_index,
  output logic                 out_last
);
  localparam logic [LOG2N-1:0] CNT_MAX = '1;

  logic [1:0]       bank_full_q, bank_full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;

  logic  [1:0] bank_wr_en;
  cplx_t       wr_sample;
  cplx_t       rd_data [2];
  cplx_t       rd_sel;
  logic        in_fire, out_fire;

  assign in_ready  = !bank_full_q[wr_bank_q];
  assign out_valid = bank_full_q[rd_bank_q];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign wr_sample = '{re: in_r, im: in_i};

  assign bank_wr_en[0] = in_fire && (wr_bank_q == 1'b0);
  assign bank_wr_en[1] = in_fire && (wr_bank_q == 1'b1);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft8_reorder_bank u_bank (
      .clk     (clk),
      .wr_en   (bank_wr_en[b]),
      .wr_addr (bitrev(wr_cnt_q)),
      .wr_data (wr_sample),
      .rd_addr (rd_cnt_q),
      .rd_data (rd_data[b])
    );
  end

  always_comb begin
    rd_sel    = rd_data[rd_bank_q];
    out_r     = '0;
    out_i     = '0;
    out_index = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_r     = rd_sel.re;
      out_i     = rd_sel.im;
      out_index = rd_cnt_q;
      out_last  = (rd_cnt_q == CNT_MAX);
    end
  end

  // Write completion and read drain in one edge always hit different banks, so both apply.
  always_comb begin
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    if (in_fire) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == CNT_MAX) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = !wr_bank_q;
      end
    end
    if (out_fire) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_cnt_q == CNT_MAX) begin
        bank_full_d[rd_bank_q] = 1'b0;
        rd_bank_d              = !rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full_q <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end
endmodule

// File: doc/fft8_bitrev_reorder.md
Name: fft8_bitrev_reorder

Overview:
- Output-side companion to the radix-2 DIF butterfly pipeline.
- Accepts the 8 complex results of one 8-point FFT frame in bit-reversed arrival order and emits them in natural frequency order (X[0]..X[7]).
- Uses a ping-pong pair of 8-entry complex banks, so frames stream at 1 sample/cycle with valid/ready handshakes on both sides.
- Sits between the last butterfly stage and the downstream consumer.

Parameters:
- DW, 16, signed width of each real/imag component.
- LOG2N, 3, log2 of frame length. Only 3 (N=8) is supported and verified.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept an input sample.
- in_r  in  DW  signed real part, bit-reversed order.
- in_i  in  DW  signed imag part, bit-reversed order.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts an output sample.
- out_r  out  DW  signed real part, natural order.
- out_i  out  DW  signed imag part, natural order.
- out_index  out  LOG2N  natural bin index of the current output.
- out_last  out  1  high with bin N-1 of each frame.

Behaviour:
- Single clock domain (clk). rst is synchronous and active-high, sampled on the rising edge of clk.
- State: bank_full[1:0], wr_bank, rd_bank, wr_cnt[LOG2N-1:0], rd_cnt[LOG2N-1:0], storage of 2 x N x (2*DW) bits in flops.
- Reset values: bank_full=0, wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0. Storage is not reset.
- Reset mid-frame discards any partial or undrained frames.
- in_ready = !bank_full[wr_bank] (combinational).
- Input accept happens at a clk edge with in_valid & in_ready:
  - write {in_r,in_i} to bank wr_bank at address bitrev(wr_cnt); wr_cnt++.
  - if wr_cnt==N-1: set bank_full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
- out_valid = bank_full[rd_bank].
- out_r/out_i = bank rd_bank at address rd_cnt when out_valid=1, else 0. Outputs are 0 during and after reset.
- out_index = rd_cnt when out_valid=1, else 0.
- out_last = out_valid & (rd_cnt==N-1).
- Output accept happens at a clk edge with out_valid & out_ready:
  - rd_cnt++.
  - if rd_cnt==N-1: clear bank_full[rd_bank], toggle rd_bank, rd_cnt wraps to 0.
- Latency: the first output is valid in the cycle after the edge that accepted the 8th input.
- Throughput: 1 sample/cycle sustained when out_ready is held high.
- No arithmetic: values pass through bit-exact, with no rounding or sign change.
- Both banks full: in_ready=0 until the read side completes a frame. in_ready rises in the cycle after the edge that drains the last sample.
- A frame-complete on write and a frame-drain on read in the same edge always target different banks; both updates take effect.
- out_ready low stalls the read side. Data, index and last stay stable while out_valid=1 and out_ready=0.
- in_valid low mid-frame holds wr_cnt. There is no timeout; a partial frame waits indefinitely.
- in_r/in_i are ignored when in_valid=0 or in_ready=0.

Decomposition:
- Shared package fft8_pkg holds:
  - DW=16, LOG2N=3, N=8.
  - bitrev function on LOG2N bits: 0,4,2,6,1,5,3,7 for inputs 0..7.
  - complex sample struct/typedef {re, im} of DW each.
- One natural sub-module, fft8_reorder_bank: an N-entry complex register file with one write port and one combinational read port, instantiated twice.
- Handshake, counters and bank_full logic live in the top module.

Test Plan:
- Single frame, in_valid and out_ready held high. Arrival j carries re=100+j, im=-(100+j).
  - Required: out_r sequence 100,104,102,106,101,105,103,107, with out_i the negation of each.
  - out_index 0..7; out_last only on the 8th output.
  - First out_valid is 1 cycle after the 8th input edge.
- Three back-to-back frames (24 consecutive inputs, values 0..23), out_ready high.
  - Required: in_ready never drops.
  - Frame 2 outputs 8,12,10,14,9,13,11,15, starting immediately after frame 1's out_last.
- out_ready held low while 16 inputs are offered.
  - Required: in_ready drops after the 16th accept; the 17th sample stalls.
  - Raising out_ready for 8 cycles drains frame 1; in_ready returns 1 the cycle after the last drain edge.
- Backpressure: toggle out_ready 1,0,1,0 during a drain.
  - Required: out_r/out_index/out_last remain stable while stalled.
  - No output is lost or duplicated.
- Reset mid-frame: assert rst after 5 inputs, then feed a full frame of values 200..207.
  - Required: out_valid=0 and out_r=out_i=0 during reset.
  - Next output frame is 200,204,202,206,201,205,203,207; the partial frame never appears.
- Bubbly input: in_valid low for 3 cycles between arrivals 3 and 4.
  - Required: output order and values identical to the first scenario.
